// File: rtl/neighbor_table_writer.sv
// neighbor_table_writer
//
// Writer side of the neighbour Q-value table held in the shared 16-bit-word,
// byte-addressed node memory. Each accepted update (neighbour ID, 11.5
// fixed-point Q-value) scans the stored IDs. A hit overwrites that entry's
// Q-value. A miss appends ID, Q-value and the incremented count, in that order,
// or drops the update when the table is already full.
//
// Optional build macro KEEP_MIN_EN: on a hit, first read the stored Q-value and
// only overwrite it when the new value is smaller (unsigned); otherwise report
// status 11 (kept) without writing.
//
// Ports:
//   clock       rising-edge clock
//   nrst        asynchronous active-low reset
//   upd_valid   update request valid
//   upd_ready   idle, able to accept an update
//   upd_id      neighbour ID
//   upd_qvalue  Q-value (11.5 fixed point, stored bit-exact)
//   address     registered memory byte address
//   data_in     memory read data for the presented address
//   data_out    registered memory write data
//   wr_en       write strobe, word written at the edge where wr_en=1
//   done        one-cycle completion pulse
//   status      00 updated, 01 appended, 10 full/dropped, 11 kept
module neighbor_table_writer #(
    parameter logic [15:0] CNT_ADDR      = 16'h068A,
    parameter logic [15:0] QV_BASE       = 16'h01C8,
    parameter logic [15:0] ID_BASE       = 16'h0208,
    parameter int unsigned MAX_NEIGHBORS = 32
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_id,
    input  logic [15:0] upd_qvalue,
    output logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        wr_en,
    output logic        done,
    output logic [1:0]  status
);

    localparam int unsigned CntW = $clog2(MAX_NEIGHBORS + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_NEIGHBORS);

    typedef enum logic [3:0] {
        StIdle,
        StRdCnt,
        StScan,
        StRdQv,
        StWrQv,
        StAppend,   // doubles as the ID write when the table has room
        StWrNq,
        StWrCnt,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     id_q, id_d;
    logic [15:0]     qv_q, qv_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] idx_q, idx_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     dout_q, dout_d;
    logic [1:0]      status_q, status_d;
    logic [CntW-1:0] cnt_rd;

    // Byte address of entry n in an array of 16-bit words.
    function automatic logic [15:0] slot_addr(input logic [15:0] base,
                                              input logic [CntW-1:0] n);
        return base + {{(15 - CntW){1'b0}}, n, 1'b0};
    endfunction

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q  <= StIdle;
            id_q     <= '0;
            qv_q     <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            addr_q   <= CNT_ADDR;
            dout_q   <= '0;
            status_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            qv_q     <= qv_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        qv_d     = qv_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        status_d = status_q;
        // A corrupted count word larger than the capacity is clamped.
        cnt_rd   = (data_in > 16'(MAX_NEIGHBORS)) ? MaxCnt : data_in[CntW-1:0];

        unique case (state_q)
            StIdle: begin
                if (upd_valid) begin
                    id_d    = upd_id;
                    qv_d    = upd_qvalue;
                    addr_d  = CNT_ADDR;
                    state_d = StRdCnt;
                end
            end
            StRdCnt: begin
                cnt_d  = cnt_rd;
                idx_d  = '0;
                addr_d = ID_BASE;
                if (cnt_rd == '0) begin
                    dout_d  = id_q;
                    state_d = StAppend;
                end else begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (data_in == id_q) begin
                    addr_d = slot_addr(QV_BASE, idx_q);
`ifdef KEEP_MIN_EN
                    state_d = StRdQv;
`else
                    dout_d  = qv_q;
                    state_d = StWrQv;
`endif
                end else if (idx_q == cnt_q - CntW'(1)) begin
                    addr_d  = slot_addr(ID_BASE, cnt_q);
                    dout_d  = id_q;
                    state_d = StAppend;
                end else begin
                    idx_d  = idx_q + CntW'(1);
                    addr_d = slot_addr(ID_BASE, idx_q + CntW'(1));
                end
            end
            StRdQv: begin
`ifdef KEEP_MIN_EN
                if (qv_q < data_in) begin
                    dout_d  = qv_q;
                    state_d = StWrQv;
                end else begin
                    status_d = 2'b11;
                    state_d  = StDone;
                end
`else
                state_d = StIdle;
`endif
            end
            StWrQv: begin
                status_d = 2'b00;
                state_d  = StDone;
            end
            StAppend: begin
                if (cnt_q == MaxCnt) begin
                    status_d = 2'b10;
                    state_d  = StDone;
                end else begin
                    addr_d  = slot_addr(QV_BASE, cnt_q);
                    dout_d  = qv_q;
                    state_d = StWrNq;
                end
            end
            StWrNq: begin
                addr_d  = CNT_ADDR;
                dout_d  = 16'(cnt_q) + 16'd1;
                state_d = StWrCnt;
            end
            StWrCnt: begin
                status_d = 2'b01;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Decoded from the state register, so the strobe falls with reset at once.
    assign wr_en = (state_q == StWrQv) || (state_q == StWrNq) || (state_q == StWrCnt) ||
                   ((state_q == StAppend) && (cnt_q != MaxCnt));

    assign upd_ready = (state_q == StIdle);
    assign done      = (state_q == StDone);
    assign address   = addr_q;
    assign data_out  = dout_q;
    assign status    = status_q;

endmodule

// File: tb/tb_neighbor_table_writer.sv
module tb_neighbor_table_writer;

    logic        clock = 1'b0;
    logic        nrst;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_id;
    logic [15:0] upd_qvalue;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        wr_en;
    logic        done;
    logic [1:0]  status;

    neighbor_table_writer dut (
        .clock      (clock),
        .nrst       (nrst),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_id     (upd_id),
        .upd_qvalue (upd_qvalue),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .wr_en      (wr_en),
        .done       (done),
        .status     (status)
    );

    always #5 clock = ~clock;

    // Word memory model covering byte addresses 0x000..0xFFF.
    logic [15:0] mem [0:2047];
    logic [31:0] wlog [$];

    assign data_in = mem[address[11:1]];

    always @(posedge clock) begin
        if (nrst && wr_en) begin
            wlog.push_back({address, data_out});
            mem[address[11:1]] <= data_out;
        end
    end

    typedef struct {
        bit              fill;
        logic [15:0]     cw;
        logic [15:0]     i0, i1, i2, q1;
        logic [15:0]     uid, uq;
        logic [1:0]      st;
        int              lat;
        int              nw;
        logic [2:0][15:0] wa;
        logic [2:0][15:0] wd;
        logic [15:0]     ca;
    } vec_t;

    vec_t vq [$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(bit fill, logic [15:0] cw, logic [15:0] i0, logic [15:0] i1,
                               logic [15:0] i2, logic [15:0] q1, logic [15:0] uid,
                               logic [15:0] uq, logic [1:0] st, int lat, int nw,
                               logic [15:0] a0, logic [15:0] d0, logic [15:0] a1,
                               logic [15:0] d1, logic [15:0] a2, logic [15:0] d2,
                               logic [15:0] ca);
        vec_t t;
        t.fill = fill; t.cw = cw; t.i0 = i0; t.i1 = i1; t.i2 = i2; t.q1 = q1;
        t.uid = uid; t.uq = uq; t.st = st; t.lat = lat; t.nw = nw;
        t.wa = {a2, a1, a0};
        t.wd = {d2, d1, d0};
        t.ca = ca;
        return t;
    endfunction

    task automatic setup(input vec_t t);
        for (int k = 0; k < 2048; k++) mem[k] = 16'h0000;
        if (t.fill) begin
            for (int k = 0; k < 32; k++) begin
                mem[(16'h0208 >> 1) + k] = 16'h1000 + 16'(k);
                mem[(16'h01C8 >> 1) + k] = 16'h0100;
            end
        end else begin
            mem[16'h0208 >> 1] = t.i0;
            mem[16'h020A >> 1] = t.i1;
            mem[16'h020C >> 1] = t.i2;
            mem[16'h01C8 >> 1] = 16'h0100;
            mem[16'h01CA >> 1] = t.q1;
            mem[16'h01CC >> 1] = 16'h0100;
        end
        mem[16'h068A >> 1] = t.cw;
    endtask

    task automatic run(input vec_t t, input int n);
        int lat;
        bit got;
        string tag;
        tag = $sformatf("v%0d", n);
        setup(t);
        wlog.delete();
        @(negedge clock);
        chk({tag, " ready_idle"}, 32'(upd_ready), 32'd1);
        upd_valid  = 1'b1;
        upd_id     = t.uid;
        upd_qvalue = t.uq;
        @(posedge clock);
        #1;
        upd_valid = 1'b0;
        chk({tag, " ready_busy"}, 32'(upd_ready), 32'd0);
        lat = 0;
        got = 1'b0;
        while (lat < 200 && !got) begin
            @(posedge clock);
            #1;
            lat++;
            if (done) got = 1'b1;
        end
        chk({tag, " latency"}, 32'(lat), 32'(t.lat));
        chk({tag, " status"}, 32'(status), 32'(t.st));
        @(posedge clock);
        #1;
        chk({tag, " done_pulse"}, {31'd0, done, upd_ready}, 32'd1);
        chk({tag, " nwrites"}, 32'(wlog.size()), 32'(t.nw));
        for (int k = 0; k < t.nw && k < wlog.size(); k++)
            chk($sformatf("%s write%0d", tag, k), wlog[k], {t.wa[k], t.wd[k]});
        chk({tag, " count_word"}, 32'(mem[16'h068A >> 1]), 32'(t.ca));
    endtask

    initial begin
        int tmo;
        nrst       = 1'b0;
        upd_valid  = 1'b0;
        upd_id     = '0;
        upd_qvalue = '0;
        #12;
        chk("rst outputs", {address, data_out}, {16'h068A, 16'h0000});
        chk("rst flags", {28'd0, upd_ready, done, wr_en, 1'b0}, 32'h8);
        chk("rst status", 32'(status), 32'd0);
        @(negedge clock);
        nrst = 1'b1;

        // Empty table append.
        vq.push_back(v(0, 0, 0, 0, 0, 16'h0100, 16'h0005, 16'h0140, 2'b01, 4, 3,
                       16'h0208, 16'h0005, 16'h01C8, 16'h0140, 16'h068A, 16'h0001, 16'h0001));
        // Hit on last of three entries.
`ifdef KEEP_MIN_EN
        vq.push_back(v(0, 3, 3, 5, 9, 16'h0100, 16'h0009, 16'h0020, 2'b00, 6, 1,
                       16'h01CC, 16'h0020, 0, 0, 0, 0, 16'h0003));
`else
        vq.push_back(v(0, 3, 3, 5, 9, 16'h0100, 16'h0009, 16'h0020, 2'b00, 5, 1,
                       16'h01CC, 16'h0020, 0, 0, 0, 0, 16'h0003));
`endif
        // Miss with room: append at index 3.
        vq.push_back(v(0, 3, 3, 5, 9, 16'h0100, 16'h0077, 16'h0055, 2'b01, 7, 3,
                       16'h020E, 16'h0077, 16'h01CE, 16'h0055, 16'h068A, 16'h0004, 16'h0004));
        // Hit on entry 0 with a larger value.
`ifdef KEEP_MIN_EN
        vq.push_back(v(0, 3, 3, 5, 9, 16'h0100, 16'h0003, 16'h0200, 2'b11, 3, 0,
                       0, 0, 0, 0, 0, 0, 16'h0003));
`else
        vq.push_back(v(0, 3, 3, 5, 9, 16'h0100, 16'h0003, 16'h0200, 2'b00, 3, 1,
                       16'h01C8, 16'h0200, 0, 0, 0, 0, 16'h0003));
`endif
        // Full table, unknown ID.
        vq.push_back(v(1, 32, 0, 0, 0, 16'h0100, 16'h00FF, 16'h0123, 2'b10, 34, 0,
                       0, 0, 0, 0, 0, 0, 16'd32));
        // Corrupted count clamps to capacity.
        vq.push_back(v(1, 16'h0050, 0, 0, 0, 16'h0100, 16'h00FF, 16'h0123, 2'b10, 34, 0,
                       0, 0, 0, 0, 0, 0, 16'h0050));
        // Full table, hit on the last entry.
`ifdef KEEP_MIN_EN
        vq.push_back(v(1, 32, 0, 0, 0, 16'h0100, 16'h101F, 16'h0033, 2'b00, 35, 1,
                       16'h0206, 16'h0033, 0, 0, 0, 0, 16'd32));
`else
        vq.push_back(v(1, 32, 0, 0, 0, 16'h0100, 16'h101F, 16'h0033, 2'b00, 34, 1,
                       16'h0206, 16'h0033, 0, 0, 0, 0, 16'd32));
`endif
        // ID present beyond the count must not match; fills the last slot.
        vq.push_back(v(1, 31, 0, 0, 0, 16'h0100, 16'h101F, 16'h0044, 2'b01, 35, 3,
                       16'h0246, 16'h101F, 16'h0206, 16'h0044, 16'h068A, 16'h0020, 16'h0020));
        // Duplicate IDs: lowest index wins.
`ifdef KEEP_MIN_EN
        vq.push_back(v(0, 3, 7, 4, 7, 16'h0100, 16'h0007, 16'h0010, 2'b00, 4, 1,
                       16'h01C8, 16'h0010, 0, 0, 0, 0, 16'h0003));
        // Keep-min: larger value kept, smaller value written.
        vq.push_back(v(0, 3, 3, 5, 9, 16'h0040, 16'h0005, 16'h0080, 2'b11, 4, 0,
                       0, 0, 0, 0, 0, 0, 16'h0003));
        vq.push_back(v(0, 3, 3, 5, 9, 16'h0040, 16'h0005, 16'h0010, 2'b00, 5, 1,
                       16'h01CA, 16'h0010, 0, 0, 0, 0, 16'h0003));
`else
        vq.push_back(v(0, 3, 7, 4, 7, 16'h0100, 16'h0007, 16'h0010, 2'b00, 3, 1,
                       16'h01C8, 16'h0010, 0, 0, 0, 0, 16'h0003));
`endif

        foreach (vq[n]) run(vq[n], n);

        // Reset during the Q-value write of an append.
        setup(vq[0]);
        wlog.delete();
        @(negedge clock);
        upd_valid  = 1'b1;
        upd_id     = 16'h0005;
        upd_qvalue = 16'h0140;
        @(posedge clock);
        #1;
        upd_valid = 1'b0;
        tmo = 0;
        while (tmo < 20 && !(wr_en && address == 16'h01C8)) begin
            @(posedge clock);
            #1;
            tmo++;
        end
        chk("rst_mid reach_wrnq", 32'(tmo < 20), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        chk("rst_mid outputs", {address, data_out}, {16'h068A, 16'h0000});
        chk("rst_mid flags", {29'd0, upd_ready, done, wr_en}, 32'h4);
        @(posedge clock);
        @(negedge clock);
        nrst = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_mid count_word", 32'(mem[16'h068A >> 1]), 32'd0);
        chk("rst_mid nwrites", 32'(wlog.size()), 32'd1);
        run(vq[0], 99);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
